// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-add multiplier. It retires one partial product per clock
//   and produces the full 2*WIDTH-bit product. Each operand can be treated as
//   unsigned or two's complement, so one unit serves MUL, MULH, MULHSU and
//   MULHU. The caller picks the low or high half of result.
//
//   The operation runs on unsigned magnitudes. The sign of the product is
//   latched at the start and applied once, in the FIX cycle. Latency is fixed
//   and does not depend on the operands: done rises WIDTH+1 edges after the
//   accepting edge.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request, accepted only on an edge where ready=1
//   flush     in   synchronous abort, back to IDLE, result untouched
//   a, b      in   WIDTH-bit operands, sampled at the accepting edge
//   a_signed  in   a is two's complement
//   b_signed  in   b is two's complement
//   ready     out  unit is idle and will accept start
//   busy      out  multiplication in progress (RUN or FIX)
//   done      out  one-cycle pulse, result newly updated
//   result    out  2*WIDTH-bit product, held until the next done
// ---------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mult;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_result;
  logic               r_done;

  logic               w_aNeg;
  logic               w_bNeg;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic               w_lastStep;
  logic [2*WIDTH-1:0] w_product;

  // An operand counts as negative only when its signed flag is set and its
  // MSB is 1. Negating the most-negative value wraps back to the same bit
  // pattern. Read as unsigned, that pattern is exactly 2^(WIDTH-1), so the
  // magnitude never needs an extra bit.
  assign w_aNeg = a_signed & a[WIDTH-1];
  assign w_bNeg = b_signed & b[WIDTH-1];
  assign w_aMag = w_aNeg ? -a : a;
  assign w_bMag = w_bNeg ? -b : b;

  // The RUN step that moves the count to WIDTH is the last partial product.
  assign w_lastStep = (r_count == CNT_W'(WIDTH - 1));

  // Apply the latched sign to the unsigned accumulator. This is
  // 2*WIDTH-bit two's complement negation.
  assign w_product = r_neg ? -r_acc : r_acc;

  // Main sequencer and datapath.
  // The multiplicand register is kept pre-shifted by the iteration count.
  // Each RUN step then only adds it and shifts it left by one, which avoids
  // a barrel shifter. The multiplier register shifts right, so its LSB is
  // always the bit of the current step. done defaults low every edge, so it
  // can only be a single-cycle pulse out of FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mult   <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= {{WIDTH{1'b0}}, w_aMag};
            r_mult  <= w_bMag;
            r_neg   <= w_aNeg ^ w_bNeg;
            r_acc   <= '0;
            r_count <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_mult[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand <= r_mcand << 1;
          r_mult  <= r_mult >> 1;
          r_count <= r_count + CNT_W'(1);
          if (w_lastStep) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result <= w_product;
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs are decoded directly from the state.
  assign ready  = (r_state == IDLE);
  assign busy   = (r_state == RUN) || (r_state == FIX);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//   Self-checking bench for seq_multiplier. It drives a 32-bit and an 8-bit
//   instance. Expected products come from plain wide arithmetic on
//   sign-extended operands. Expected latencies come from the fixed
//   WIDTH+1 edge count between the accepting edge and done.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;

  logic        start32, as32, bs32;
  logic [31:0] a32, b32;
  logic        ready32, busy32, done32;
  logic [63:0] res32;

  logic        start8, as8, bs8, flush8;
  logic [7:0]  a8, b8;
  logic        ready8, busy8, done8;
  logic [15:0] res8;

  int checks = 0;
  int errors = 0;

  // 10-unit clock period shared by both instances.
  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(32)) u_mul32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .flush(flush),
    .a(a32), .b(b32), .a_signed(as32), .b_signed(bs32),
    .ready(ready32), .busy(busy32), .done(done32), .result(res32)
  );

  seq_multiplier #(.WIDTH(8)) u_mul8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .flush(flush8),
    .a(a8), .b(b8), .a_signed(as8), .b_signed(bs8),
    .ready(ready8), .busy(busy8), .done(done8), .result(res8)
  );

  // Reference products.
  // Each operand is sign-extended when its flag is set, the two are
  // multiplied, and the low 2*WIDTH bits are kept.
  function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic as, input logic bs);
    logic signed [65:0] ea, eb, p;
    ea = {{34{as & a[31]}}, a};
    eb = {{34{bs & b[31]}}, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic as, input logic bs);
    logic signed [17:0] ea, eb, p;
    ea = {{10{as & a[7]}}, a};
    eb = {{10{bs & b[7]}}, b};
    p  = ea * eb;
    return p[15:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one request to the 32-bit unit for a single edge. The operands
  // are then scrambled to show that they only matter at the accepting edge.
  task automatic applyStimulus32(input logic [31:0] a, input logic [31:0] b,
                                 input logic as, input logic bs);
    start32 = 1'b1;
    a32 = a; b32 = b; as32 = as; bs32 = bs;
    tick();
    start32 = 1'b0;
    a32 = $urandom; b32 = $urandom; as32 = 1'($urandom); bs32 = 1'($urandom);
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b,
                                input logic as, input logic bs);
    start8 = 1'b1;
    a8 = a; b8 = b; as8 = as; bs8 = bs;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); as8 = 1'($urandom); bs8 = 1'($urandom);
  endtask

  // Count the edges after acceptance until done is seen, with a bound.
  // Also count any cycle where ready was not low while waiting.
  task automatic waitDone32(output int lat, output int readyHigh);
    lat = 0; readyHigh = 0;
    while (done32 !== 1'b1 && lat < 200) begin
      if (ready32 !== 1'b0) readyHigh++;
      tick();
      lat++;
    end
  endtask

  task automatic waitDone8(output int lat, output int readyHigh);
    lat = 0; readyHigh = 0;
    while (done8 !== 1'b1 && lat < 100) begin
      if (ready8 !== 1'b0) readyHigh++;
      tick();
      lat++;
    end
  endtask

  // Full 32-bit operation: latency, busy window, product, then a one-cycle
  // done pulse with the result held afterwards.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic as,
                      input logic bs, input string tag, output logic [63:0] got);
    int lat, rh;
    logic [63:0] exp;
    exp = model32(a, b, as, bs);
    applyStimulus32(a, b, as, bs);
    waitDone32(lat, rh);
    checkOutput({tag, " latency"}, 64'(lat), 64'd33);
    checkOutput({tag, " ready low"}, 64'(rh), 64'd0);
    checkOutput({tag, " result"}, res32, exp);
    got = res32;
    tick();
    checkOutput({tag, " done pulse"}, {63'd0, done32}, 64'd0);
    checkOutput({tag, " hold"}, res32, exp);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic as,
                     input logic bs, input string tag, output logic [15:0] got);
    int lat, rh;
    logic [15:0] exp;
    exp = model8(a, b, as, bs);
    applyStimulus8(a, b, as, bs);
    waitDone8(lat, rh);
    checkOutput({tag, " latency"}, 64'(lat), 64'd9);
    checkOutput({tag, " ready low"}, 64'(rh), 64'd0);
    checkOutput({tag, " result"}, {48'd0, res8}, {48'd0, exp});
    got = res8;
    tick();
    checkOutput({tag, " done pulse"}, {63'd0, done8}, 64'd0);
  endtask

  // Keeps the run bounded even if done never arrives.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] got, first;
    logic [15:0] got8;
    logic [31:0] ra, rb;
    int lat, rh, gap, hits, lows;

    rst_n = 1'b0; flush = 1'b0; flush8 = 1'b0;
    start32 = 1'b0; a32 = '0; b32 = '0; as32 = 1'b0; bs32 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; as8 = 1'b0; bs8 = 1'b0;

    // Reset state.
    #12;
    checkOutput("reset ready32", {63'd0, ready32}, 64'd1);
    checkOutput("reset busy32", {63'd0, busy32}, 64'd0);
    checkOutput("reset done32", {63'd0, done32}, 64'd0);
    checkOutput("reset result32", res32, 64'd0);
    checkOutput("reset ready8", {63'd0, ready8}, 64'd1);
    checkOutput("reset result8", {48'd0, res8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed products.
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "umax", got);
    checkOutput("umax const", got, 64'hFFFFFFFE00000001);
    op32(32'hFFFFFFF9, 32'd6, 1'b1, 1'b1, "ss -7x6", got);
    checkOutput("ss -7x6 const", got, 64'hFFFFFFFFFFFFFFD6);
    op32(32'hFFFFFFF9, 32'd6, 1'b0, 1'b1, "us mix", got);
    checkOutput("us mix const", got, 64'h00000005FFFFFFD6);
    op32(32'h80000000, 32'h80000000, 1'b1, 1'b1, "minneg32", got);
    checkOutput("minneg32 const", got, 64'h4000000000000000);
    op8(8'h80, 8'h80, 1'b1, 1'b1, "minneg8", got8);
    checkOutput("minneg8 const", {48'd0, got8}, 64'h4000);
    op8(8'h80, 8'hFF, 1'b1, 1'b0, "su8", got8);
    checkOutput("su8 const", {48'd0, got8}, 64'h8080);

    // Random operands and signedness.
    for (int i = 0; i < 12; i++) begin
      op32($urandom, $urandom, 1'($urandom), 1'($urandom), "rand32", got);
    end
    for (int i = 0; i < 12; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "rand8", got8);
    end

    // Back-to-back: the next start is raised in the done cycle, and a
    // second start pulsed mid-RUN must be ignored.
    first = model32(32'd12345, 32'd678, 1'b0, 1'b0);
    applyStimulus32(32'd12345, 32'd678, 1'b0, 1'b0);
    waitDone32(lat, rh);
    checkOutput("b2b first latency", 64'(lat), 64'd33);
    checkOutput("b2b first result", res32, first);
    start32 = 1'b1; a32 = 32'd3; b32 = 32'd5; as32 = 1'b0; bs32 = 1'b0;
    tick();
    start32 = 1'b0;
    checkOutput("b2b done falls", {63'd0, done32}, 64'd0);
    checkOutput("b2b accepted", {63'd0, busy32}, 64'd1);
    checkOutput("b2b hold", res32, first);
    repeat (5) tick();
    start32 = 1'b1; a32 = 32'd7; b32 = 32'd9;
    tick();
    start32 = 1'b0;
    checkOutput("b2b hold mid", res32, first);
    waitDone32(lat, rh);
    gap = 7 + lat;
    checkOutput("b2b gap", 64'(gap), 64'd34);
    checkOutput("b2b ready low", 64'(rh), 64'd0);
    checkOutput("b2b result", res32, 64'd15);
    tick();
    checkOutput("b2b done pulse", {63'd0, done32}, 64'd0);

    // Flush at count=10, with a start in the same cycle that must be ignored.
    ra = $urandom; rb = $urandom;
    applyStimulus32(ra, rb, 1'b0, 1'b0);
    repeat (10) tick();
    flush = 1'b1; start32 = 1'b1; a32 = 32'd2; b32 = 32'd2;
    tick();
    flush = 1'b0; start32 = 1'b0;
    checkOutput("flush ready", {63'd0, ready32}, 64'd1);
    checkOutput("flush busy", {63'd0, busy32}, 64'd0);
    checkOutput("flush result", res32, 64'd15);
    hits = 0; lows = 0;
    for (int i = 0; i < 40; i++) begin
      if (done32 !== 1'b0) hits++;
      if (ready32 !== 1'b1) lows++;
      tick();
    end
    checkOutput("flush no done", 64'(hits), 64'd0);
    checkOutput("flush stays idle", 64'(lows), 64'd0);
    checkOutput("flush result kept", res32, 64'd15);
    op32($urandom, $urandom, 1'b1, 1'b0, "after flush", got);

    // Asynchronous reset between edges mid-RUN.
    applyStimulus32(32'hDEADBEEF, 32'h1234, 1'b1, 1'b1);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst result", res32, 64'd0);
    checkOutput("arst done", {63'd0, done32}, 64'd0);
    checkOutput("arst ready", {63'd0, ready32}, 64'd1);
    checkOutput("arst busy", {63'd0, busy32}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    op32(32'd0, 32'h12345678, 1'b0, 1'b0, "after arst", got);
    checkOutput("after arst const", got, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
